// File: rtl/ahb_pkg.sv
// ahb_pkg: shared state type, response codes and defaults for the AHB-lite master port.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Provides fallback widths when AHB_ADDR_WIDTH / AHB_DATA_WIDTH are not set.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

package ahb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CAPT = 3'd4,
    ST_RESP = 3'd5
  } mst_state_t;

  localparam logic RSP_OKAY = 1'b0;
  localparam logic RSP_ERR  = 1'b1;

  localparam int TIMEOUT_DFLT = 255;

endpackage

// File: rtl/ahb_mst_timer.sv
// ahb_mst_timer: loadable down-counter used as a per-phase watchdog.
// Latency: expired is combinational from the count; load/clr/decrement take effect next cycle.
// Backpressure: none; counts only while en is high and stops at zero.
module ahb_mst_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Load wins over clear so a phase entry always starts a fresh count.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // A count of one means this is the last allowed cycle of the phase.
  assign expired = en && (cnt_q == W'(1));

endmodule

// File: rtl/ahb_mst_port.sv
// ahb_mst_port: single-outstanding CPU load/store to AHB-lite bus-request/address/data sequencer.
// Latency: rsp_valid 5 cycles after the accept cycle, +1 per REQ cycle without grant, +2 per lost grant, +1 per DATA wait.
// Backpressure: req_ready only in IDLE; response held until rsp_ready. Optional watchdog: AHB_MST_TIMEOUT_EN.
module ahb_mst_port
  import ahb_pkg::*;
#(
  parameter int ADDR_W  = `AHB_ADDR_WIDTH,
  parameter int DATA_W  = `AHB_DATA_WIDTH,
  parameter int TIMEOUT = TIMEOUT_DFLT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              hbusreq,
  input  logic              hgrant,
  output logic [ADDR_W-1:0] haddr,
  output logic              haddr_ctrl,
  output logic              hwrite,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hdata_s2m,
  input  logic              hready_s2m,
  input  logic              hresp_s2m
);

  mst_state_t        state_d, state_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              wr_d, wr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic [DATA_W-1:0] rsp_rdata_d, rsp_rdata_q;
  logic              rsp_err_d, rsp_err_q;
  logic              tmo_expired;
  logic              drive_bus;

  // Next-state, request latch (IDLE only) and response capture.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wr_d    = req_write;
          wdata_d = req_wdata;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (hgrant) begin
          state_d = ST_ADDR;
        end else if (tmo_expired) begin
          rsp_rdata_d = '0;
          rsp_err_d   = RSP_ERR;
          state_d     = ST_RESP;
        end
      end
      // Grant lost during the address cycle: re-arbitrate.
      ST_ADDR: state_d = hgrant ? ST_DATA : ST_REQ;
      ST_DATA: begin
        if (hready_s2m) begin
          state_d = ST_CAPT;
        end else if (tmo_expired) begin
          rsp_rdata_d = '0;
          rsp_err_d   = RSP_ERR;
          state_d     = ST_RESP;
        end
      end
      // Error responses never carry data, even on a load.
      ST_CAPT: begin
        rsp_rdata_d = (wr_q || hresp_s2m) ? '0 : hdata_s2m;
        rsp_err_d   = hresp_s2m ? RSP_ERR : RSP_OKAY;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latch and response registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef AHB_MST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic tmo_run;
  logic tmo_load;
  assign tmo_run  = (state_q == ST_REQ) || (state_q == ST_DATA);
  assign tmo_load = (state_d != state_q) && ((state_d == ST_REQ) || (state_d == ST_DATA));

  ahb_mst_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmo_load),
    .clr      (!tmo_run),
    .en       (tmo_run),
    .load_val (TW'(TIMEOUT)),
    .expired  (tmo_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo_expired    = 1'b0;
`endif

  // Bus-side and handshake outputs decoded from state; bus fields are zero outside REQ..CAPT.
  assign drive_bus  = (state_q == ST_REQ) || (state_q == ST_ADDR) ||
                      (state_q == ST_DATA) || (state_q == ST_CAPT);
  assign hbusreq    = ((state_q == ST_REQ) && !(tmo_expired && !hgrant)) || (state_q == ST_ADDR);
  assign haddr_ctrl = (state_q == ST_ADDR);
  assign haddr      = drive_bus ? addr_q  : '0;
  assign hwrite     = drive_bus ? wr_q    : 1'b0;
  assign hwdata     = drive_bus ? wdata_q : '0;
  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_ahb_mst_port.sv
// tb_ahb_mst_port: randomized transactions against a cycle-schedule model of the port.
// Latency: model predicts every cycle from grant delay, grant loss, wait states and response stall.
// Backpressure: stalls rsp_ready and toggles ignored inputs to show they have no effect.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module tb_ahb_mst_port;
  localparam int AW     = `AHB_ADDR_WIDTH;
  localparam int DW     = `AHB_DATA_WIDTH;
  localparam int TB_TMO = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          hbusreq, hgrant, haddr_ctrl, hwrite;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata, hdata_s2m;
  logic          hready_s2m, hresp_s2m;

  always #5 clk = ~clk;

  ahb_mst_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TB_TMO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .hbusreq(hbusreq), .hgrant(hgrant), .haddr(haddr), .haddr_ctrl(haddr_ctrl),
    .hwrite(hwrite), .hwdata(hwdata), .hdata_s2m(hdata_s2m),
    .hready_s2m(hready_s2m), .hresp_s2m(hresp_s2m)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Per-transaction schedule (cycle 0 = accept cycle).
  int            s_gdly, s_aph, s_ws, s_cap, s_rsp, s_last;
  bit            s_drop, s_err;
  logic [DW-1:0] s_rd;

  // Inputs for cycle n: bus inputs follow the schedule where they matter, random elsewhere.
  task automatic drv(input int n);
    req_valid = 1'($urandom_range(1, 0));
    req_addr  = AW'($urandom);
    req_write = 1'($urandom_range(1, 0));
    req_wdata = DW'($urandom);
    if (n <= s_aph) hgrant = (n >= s_gdly + 1) && !(s_drop && n == s_gdly + 2);
    else            hgrant = 1'($urandom_range(1, 0));
    if (n > s_aph && n <= s_aph + 1 + s_ws) hready_s2m = (n == s_aph + 1 + s_ws);
    else                                    hready_s2m = 1'($urandom_range(1, 0));
    hdata_s2m = (n == s_cap) ? s_rd  : DW'($urandom);
    hresp_s2m = (n == s_cap) ? s_err : 1'($urandom_range(1, 0));
    rsp_ready = (n >= s_rsp) ? (n >= s_last) : 1'($urandom_range(1, 0));
  endtask

  // One transaction; entered and left at a negedge of an IDLE cycle.
  task automatic run_txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                         input int gdly, input bit drop, input int ws, input bit err,
                         input logic [DW-1:0] rd, input int rdly);
    logic [DW-1:0] exp_rd;
    logic [4:0]    exp_ctl;
    s_gdly = gdly; s_drop = drop; s_ws = ws; s_err = err; s_rd = rd;
    s_aph  = gdly + 2 + (drop ? 2 : 0);
    s_cap  = s_aph + 2 + ws;
    s_rsp  = s_cap + 1;
    s_last = s_rsp + rdly;
    exp_rd = (w || err) ? '0 : rd;
    chk("accept_rdy", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = wd;
    hgrant = 1'($urandom_range(1, 0)); hready_s2m = 1'($urandom_range(1, 0));
    rsp_ready = 1'($urandom_range(1, 0));
    for (int c = 1; c <= s_last + 1; c++) begin
      @(negedge clk);
      if (c <= s_last) begin
        exp_ctl = {c <= s_aph, (c == gdly + 2) || (drop && c == gdly + 4), w && (c <= s_cap),
                   1'b0, c >= s_rsp};
        chk("ctl", 64'({hbusreq, haddr_ctrl, hwrite, req_ready, rsp_valid}), 64'(exp_ctl));
        chk("haddr", 64'(haddr), (c <= s_cap) ? 64'(a) : 64'(0));
        chk("hwdata", 64'(hwdata), (c <= s_cap) ? 64'(wd) : 64'(0));
        if (c == s_rsp) begin
          chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
          chk("rsp_err", 64'(rsp_err), 64'(err));
        end
        drv(c);
      end else begin
        chk("idle_ctl", 64'({hbusreq, haddr_ctrl, hwrite, req_ready, rsp_valid}), 64'(5'b00010));
        chk("hold_rdata", 64'(rsp_rdata), 64'(exp_rd));
        chk("hold_err", 64'(rsp_err), 64'(err));
        req_valid = 1'b0;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 64'({hbusreq, haddr_ctrl, hwrite, req_ready, rsp_valid, rsp_err}), 64'(6'b000100));
    chk({tag, "_bus"}, 64'(haddr) | 64'(hwdata) | 64'(rsp_rdata), 64'(0));
  endtask

  initial begin
    int first;
    int nrsp;
    rstn = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    rsp_ready = 1'b0; hgrant = 1'b0; hdata_s2m = '0; hready_s2m = 1'b0; hresp_s2m = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Directed: read no wait, write 3 waits, grant delay + loss, slave error with stalled rsp_ready.
    run_txn(AW'(32'h0000_1000), 1'b0, DW'(32'h0), 0, 1'b0, 0, 1'b0, DW'(32'hDEAD_BEEF), 0);
    run_txn(AW'(32'h0000_2000), 1'b1, DW'(32'h1234_5678), 0, 1'b0, 3, 1'b0, DW'(32'h5555_AAAA), 0);
    run_txn(AW'(32'h0000_3004), 1'b0, DW'(32'h0), 4, 1'b1, 0, 1'b0, DW'(32'hCAFE_F00D), 1);
    run_txn(AW'(32'h0000_4008), 1'b0, DW'(32'h0), 0, 1'b0, 1, 1'b1, DW'(32'hFFFF_FFFF), 3);

    for (int i = 0; i < 40; i++) begin
      run_txn(AW'($urandom), 1'($urandom_range(1, 0)), DW'($urandom),
              int'($urandom_range(4, 0)), $urandom_range(3, 0) == 0, int'($urandom_range(5, 0)),
              $urandom_range(4, 0) == 0, DW'($urandom), int'($urandom_range(3, 0)));
    end

    // Reset in DATA: abandon the transfer, no response afterwards.
    req_valid = 1'b1; req_addr = AW'(32'h0000_5000); req_write = 1'b1;
    req_wdata = DW'(32'hA5A5_0F0F); hgrant = 1'b1; hready_s2m = 1'b0; rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    req_valid = 1'b0;
    chk("mid_hwdata", 64'(hwdata), 64'(DW'(32'hA5A5_0F0F)));
    rstn = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rstn = 1'b1; hready_s2m = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid || !req_ready) nrsp++;
    end
    chk("post_reset_quiet", 64'(nrsp), 64'(0));

`ifdef AHB_MST_TIMEOUT_EN
    // DATA watchdog: grant immediately, slave never ready.
    req_valid = 1'b1; req_addr = AW'(32'h0000_6000); req_write = 1'b0;
    hgrant = 1'b1; hready_s2m = 1'b0; hresp_s2m = 1'b0; rsp_ready = 1'b0;
    first = -1;
    for (int c = 1; c <= 20 && first < 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) first = c;
    end
    chk("tmo_data_lat", 64'(first), 64'(3 + TB_TMO));
    chk("tmo_data_err", 64'(rsp_err), 64'(1));
    chk("tmo_data_rdata", 64'(rsp_rdata), 64'(0));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    // REQ watchdog: grant never arrives; hbusreq must drop in the expiring cycle.
    req_valid = 1'b1; hgrant = 1'b0;
    first = -1;
    for (int c = 1; c <= 20 && first < 0; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (c == TB_TMO - 1) chk("tmo_req_busreq", 64'(hbusreq), 64'(1));
      if (c == TB_TMO)     chk("tmo_req_drop", 64'(hbusreq), 64'(0));
      if (rsp_valid) first = c;
    end
    chk("tmo_req_lat", 64'(first), 64'(1 + TB_TMO));
    chk("tmo_req_err", 64'(rsp_err), 64'(1));
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("tmo_idle", 64'(req_ready), 64'(1));
`else
    // No watchdog: a never-ready slave must hang the port indefinitely.
    req_valid = 1'b1; req_addr = AW'(32'h0000_6000); req_write = 1'b0;
    hgrant = 1'b1; hready_s2m = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    nrsp = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    chk("no_tmo_rsp", 64'(nrsp), 64'(0));
    chk("no_tmo_data", 64'({hbusreq, req_ready}), 64'(2'b00));
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("no_tmo_recover", 64'(req_ready), 64'(1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
